// File: rtl/sim_pkg.sv
// Shared types and constants for the simulation memory model and harness glue.
// Struct widths follow the harness default XLEN.
package sim_pkg;

    localparam int unsigned SIM_XLEN    = 32;
    localparam int unsigned TOHOST_PASS = 1;

    typedef struct packed {
        logic                  r_v;
        logic                  w_v;
        logic [SIM_XLEN-1:0]   adr;
        logic [SIM_XLEN-1:0]   data;
        logic [SIM_XLEN/8-1:0] strobe;
    } mem_req_t;

    typedef struct packed {
        logic                ack;
        logic                err;
        logic [SIM_XLEN-1:0] resp;
    } mem_rsp_t;

endpackage

// File: rtl/sim_delay_line.sv
// Valid/data shift register with asynchronous clear; output is DEPTH cycles behind input.
module sim_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/sim_mem.sv
// Word-addressed simulation memory with pipelined responses, bounds checking and a
// tohost end-of-test mailbox.
module sim_mem
    import sim_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     DEPTH      = 16384,
    parameter int unsigned     LATENCY    = 1,
    parameter logic [XLEN-1:0] TOHOST_ADR = 32'h8000_1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r_v,
    input  logic              w_v,
    input  logic [XLEN-1:0]   adr,
    input  logic [XLEN-1:0]   data,
    input  logic [XLEN/8-1:0] strobe,
    output logic [XLEN-1:0]   resp,
    output logic              ack,
    output logic              err,
    output logic              test_done,
    output logic              test_pass,
    output logic [XLEN-2:0]   test_code
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned PW = XLEN + 1;

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("sim_mem: LATENCY %0d outside 1..8", LATENCY);
    end

    logic [XLEN-1:0] r_mem [DEPTH];
    logic            r_done;
    logic            r_pass;
    logic [XLEN-1:0] r_tohost;

    logic [IW-1:0]   w_idx;
    logic            w_is_tohost;
    logic            w_oor;
    logic            w_req;
    logic [XLEN-1:0] w_rd_data;
    logic [PW-1:0]   w_pipe_in;
    logic [PW-1:0]   w_pipe_out;
    logic            w_pipe_v;

    assign w_idx       = adr[2 +: IW];
    assign w_is_tohost = (adr == TOHOST_ADR);
    assign w_oor       = ((adr >> (IW + 2)) != '0) && !w_is_tohost;
    assign w_req       = r_v || w_v;

    // A concurrent write wins over the read, so its response carries zero data.
    always_comb begin
        w_rd_data = '0;
        if (r_v && !w_v) begin
            if (w_is_tohost) begin
                w_rd_data = r_tohost;
            end else if (!w_oor) begin
                w_rd_data = r_mem[w_idx];
            end
        end
    end

    always_comb begin
        w_pipe_in = '0;
        if (w_req) begin
            w_pipe_in = {w_oor, w_rd_data};
        end
    end

    // Array has no reset so preloaded images survive a harness reset.
    always_ff @(posedge clk) begin
        if (w_v && !w_oor && !w_is_tohost) begin
            for (int b = 0; b < NB; b++) begin
                if (strobe[b]) begin
                    r_mem[w_idx][8*b +: 8] <= data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_tohost <= '0;
        end else if (w_v && w_is_tohost && !r_done) begin
            r_done   <= 1'b1;
            r_pass   <= (data == XLEN'(TOHOST_PASS));
            r_tohost <= data;
        end
    end

    sim_delay_line #(
        .WIDTH (PW),
        .DEPTH (LATENCY)
    ) u_rsp_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_req),
        .i_data  (w_pipe_in),
        .o_valid (w_pipe_v),
        .o_data  (w_pipe_out)
    );

    assign ack         = w_pipe_v;
    assign {err, resp} = w_pipe_out;
    assign test_done   = r_done;
    assign test_pass   = r_pass;
    assign test_code   = r_tohost[XLEN-1:1];

endmodule

// File: tb/tb_sim_mem.sv
// Directed bench for sim_mem: two instances (LATENCY 3 and 2) share one request stream.
module tb_sim_mem;
    import sim_pkg::*;

    localparam logic [31:0] TOHOST = 32'h8000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_v = 1'b0;
    logic        w_v = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] data = '0;
    logic [3:0]  strobe = '0;

    logic [31:0] resp3, resp2;
    logic        ack3, ack2, err3, err2;
    logic        done3, done2, pass3, pass2;
    logic [30:0] code3, code2;
    mem_rsp_t    rsp3, rsp2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rsp3 = '{ack: ack3, err: err3, resp: resp3};
    assign rsp2 = '{ack: ack2, err: err2, resp: resp2};

    sim_mem #(
        .XLEN(32), .DEPTH(16384), .LATENCY(3), .TOHOST_ADR(TOHOST)
    ) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .r_v(r_v), .w_v(w_v), .adr(adr), .data(data),
        .strobe(strobe), .resp(resp3), .ack(ack3), .err(err3), .test_done(done3),
        .test_pass(pass3), .test_code(code3)
    );

    sim_mem #(
        .XLEN(32), .DEPTH(16384), .LATENCY(2), .TOHOST_ADR(TOHOST)
    ) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .r_v(r_v), .w_v(w_v), .adr(adr), .data(data),
        .strobe(strobe), .resp(resp2), .ack(ack2), .err(err2), .test_done(done2),
        .test_pass(pass2), .test_code(code2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r_v = 1'b0; w_v = 1'b0; adr = '0; data = '0; strobe = '0;
    endtask

    task automatic drain();
        idle();
        repeat (5) tick();
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        r_v = 1'b0; w_v = 1'b1; adr = a; data = d; strobe = s;
        tick();
        idle();
    endtask

    // Read on the shared stream and check the LATENCY=3 instance in cycle 3.
    task automatic read_l3(input string tag, input logic [31:0] a, input logic [31:0] exp,
                           input logic exp_err);
        r_v = 1'b1; w_v = 1'b0; adr = a;
        tick();
        idle();
        repeat (2) tick();
        check({tag, "_ack"}, 32'(rsp3.ack), 32'd1);
        check({tag, "_resp"}, rsp3.resp, exp);
        check({tag, "_err"}, 32'(rsp3.err), 32'(exp_err));
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_ack", 32'(ack3), 32'd0);
        check("rst_err", 32'(err3), 32'd0);
        check("rst_resp", resp3, 32'd0);
        check("rst_done", 32'(done3), 32'd0);
        check("rst_pass", 32'(pass3), 32'd0);
        check("rst_code", 32'(code3), 32'd0);
        check("rst_ack_l2", 32'(ack2), 32'd0);
        rst_n = 1'b1;
        tick();

        // Preload through the write port.
        write_word(32'h10, 32'hDEAD_BEEF, 4'hF);
        write_word(32'h20, 32'hAAAA_AAAA, 4'hF);
        for (int i = 0; i < 4; i++) write_word(32'(4 * i), 32'(32'h100 + i), 4'hF);
        drain();

        // LATENCY=3 ack timing.
        r_v = 1'b1; adr = 32'h10;
        check("lat_c0_ack", 32'(ack3), 32'd0);
        tick();
        idle();
        check("lat_c1_ack", 32'(ack3), 32'd0);
        tick();
        check("lat_c2_ack", 32'(ack3), 32'd0);
        tick();
        check("lat_c3_ack", 32'(ack3), 32'd1);
        check("lat_c3_resp", resp3, 32'hDEAD_BEEF);
        check("lat_c3_err", 32'(err3), 32'd0);
        tick();
        check("lat_c4_ack", 32'(ack3), 32'd0);
        drain();

        // Byte-strobed write, read in the following cycle.
        write_word(32'h20, 32'h1122_3344, 4'b0101);
        read_l3("strobe_merge", 32'h20, 32'hAA22_AA44, 1'b0);
        drain();

        // Back-to-back reads on LATENCY=2: acks in cycles 2..5, in order.
        for (int c = 0; c < 7; c++) begin
            r_v = (c < 4);
            adr = 32'(4 * c);
            check($sformatf("b2b_c%0d_ack", c), 32'(ack2), 32'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) check($sformatf("b2b_c%0d_resp", c), resp2, 32'(32'h100 + c - 2));
            tick();
        end
        drain();

        // Out-of-range read and write; index bits alias word 0, which must be untouched.
        read_l3("oor_read", 32'hFFFF_0000, 32'd0, 1'b1);
        write_word(32'hFFFF_0000, 32'h1234_5678, 4'hF);
        repeat (2) tick();
        check("oor_write_ack", 32'(ack3), 32'd1);
        check("oor_write_err", 32'(err3), 32'd1);
        drain();
        read_l3("oor_word0", 32'h0, 32'h100, 1'b0);
        drain();

        // Simultaneous read and write: single ack with zero data, write lands.
        r_v = 1'b1; w_v = 1'b1; adr = 32'h24; data = 32'h5555_AAAA; strobe = 4'hF;
        tick();
        idle();
        repeat (2) tick();
        check("rw_ack", 32'(ack3), 32'd1);
        check("rw_resp", resp3, 32'd0);
        tick();
        check("rw_single_ack", 32'(ack3), 32'd0);
        drain();
        read_l3("rw_written", 32'h24, 32'h5555_AAAA, 1'b0);
        drain();

        // Tohost pass.
        w_v = 1'b1; adr = TOHOST; data = 32'd1; strobe = 4'hF;
        check("th1_c0_done", 32'(done3), 32'd0);
        tick();
        idle();
        check("th1_done", 32'(done3), 32'd1);
        check("th1_pass", 32'(pass3), 32'd1);
        check("th1_code", 32'(code3), 32'd0);
        repeat (2) tick();
        check("th1_ack", 32'(ack3), 32'd1);
        check("th1_err", 32'(err3), 32'd0);
        drain();
        rst_n = 1'b0;
        #1;
        check("th_rst_done", 32'(done3), 32'd0);
        check("th_rst_pass", 32'(pass3), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Tohost fail with code 3; a later pass write is ignored.
        write_word(TOHOST, 32'd7, 4'hF);
        check("th7_done", 32'(done3), 32'd1);
        check("th7_pass", 32'(pass3), 32'd0);
        check("th7_code", 32'(code3), 32'd3);
        drain();
        write_word(TOHOST, 32'd1, 4'hF);
        drain();
        check("th_second_pass", 32'(pass3), 32'd0);
        check("th_second_code", 32'(code3), 32'd3);
        read_l3("th_read", TOHOST, 32'd7, 1'b0);
        drain();

        // Reset while a read is in flight: its ack is dropped, array survives.
        r_v = 1'b1; adr = 32'h10;
        tick();
        idle();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(ack3), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("midrst_k%0d_ack", k), 32'(ack3), 32'd0);
            tick();
        end
        read_l3("post_rst_read", 32'h10, 32'hDEAD_BEEF, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
